sys_ctrl_alu_sequencer: RTL and testbench
=========================================

// Module: sys_ctrl_alu_sequencer
// PURPOSE
//  Command-frame sequencer for the register file and the registered ALU. It consumes parsed UART RX
//  bytes, executes register write/read and ALU commands, and streams results to the TX async FIFO.
//  It drives the ALU enable, function code and clock-gate enable so the ALU clock runs only while an
//  operation is in flight.
// PARAMETERS
//  DATA_WIDTH     8   width of RX/TX bytes, register-file data and ALU operands
//  ADDR_WIDTH     4   register-file address width; operand A at addr 0, operand B at addr 1
//  FUN_WIDTH      4   ALU function-code width
// PORTS
//  CLK            in   1              system clock
//  RST            in   1              asynchronous, active-low reset
//  RX_P_DATA      in   DATA_WIDTH     received byte
//  RX_D_VLD       in   1              one-cycle strobe qualifying RX_P_DATA
//  ALU_OUT        in   2*DATA_WIDTH   ALU result (registered in ALU)
//  ALU_OUT_VLD    in   1              ALU result valid, one cycle after ALU_EN
//  RF_RD_DATA     in   DATA_WIDTH     register-file read data
//  RF_RD_DATA_VLD in   1              read data valid, one cycle after RF_RD_EN
//  FIFO_FULL      in   1              TX FIFO full; no TX write permitted while high
//  ALU_EN         out  1              ALU enable pulse
//  ALU_FUN        out  FUN_WIDTH      ALU function code, held from capture until next ALU command
//  CLK_GATE_EN    out  1              ALU clock-gate enable
//  RF_ADDR        out  ADDR_WIDTH     register-file address
//  RF_WR_EN       out  1              register-file write strobe
//  RF_RD_EN       out  1              register-file read strobe
//  RF_WR_DATA     out  DATA_WIDTH     register-file write data
//  TX_P_DATA      out  DATA_WIDTH     byte to TX FIFO
//  TX_D_VLD       out  1              TX FIFO write strobe
// BEHAVIOUR
//  Reset: all outputs 0 and state IDLE; internal address, result and function registers cleared.
//  Reset mid-frame: the frame is discarded and no partial write or TX is emitted.
//  Commands, first byte in IDLE:
//    0xAA  reg write         : addr, data
//    0xBB  reg read          : addr
//    0xCC  ALU with operands : A, B, fun
//    0xDD  ALU no operands   : fun
//    Any other byte in IDLE is ignored.
//  FSM: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, FUN, ALU_EXEC, ALU_WAIT,
//    TX_LSB, TX_MSB, TX_RD. Waiting states advance only on RX_D_VLD.
//  WR_ADDR: latch addr (low ADDR_WIDTH bits).
//  WR_DATA: 1-cycle RF_WR_EN with latched addr and data, then go to IDLE.
//  RD_ADDR: 1-cycle RF_RD_EN, then go to RD_WAIT. On RF_RD_DATA_VLD, capture data and go to TX_RD.
//  OP_A / OP_B: 1-cycle RF_WR_EN to addr 0 / addr 1 with the received byte.
//  FUN: latch fun into ALU_FUN, then go to ALU_EXEC.
//  ALU_EXEC: ALU_EN=1 for exactly 1 cycle, then go to ALU_WAIT.
//  ALU_WAIT: on ALU_OUT_VLD, capture the full 2*DATA_WIDTH result, then go to TX_LSB.
//  CLK_GATE_EN = 1 in FUN, ALU_EXEC and ALU_WAIT; 0 everywhere else.
//  TX: TX_LSB sends result[DATA_WIDTH-1:0], then TX_MSB sends the upper byte; TX_RD sends the read byte.
//  Each TX byte is a 1-cycle TX_D_VLD, issued only in a cycle where FIFO_FULL=0. While full, the
//    state holds and TX_P_DATA stays stable. After the last byte, return to IDLE.
//  RX_D_VLD in any non-receiving state (RD_WAIT, ALU_EXEC, ALU_WAIT, TX_*): byte dropped, no side effects.
//  All strobes (ALU_EN, RF_WR_EN, RF_RD_EN, TX_D_VLD) are registered, single-cycle and mutually
//    exclusive. Result capture is unsigned and full width; no truncation.
// TESTING
//  Frame AA,05,3C -> one RF_WR_EN with RF_ADDR=5 and RF_WR_DATA=0x3C; state back to IDLE;
//    TX_D_VLD never asserted.
//  Frame BB,05 with RF_RD_DATA=0x3C -> exactly one RF_RD_EN, then one TX_D_VLD with TX_P_DATA=0x3C.
//  Frame CC,0A,14,02 (multiply) with ALU_OUT=0x00C8 -> RF writes 0x0A@0 and 0x14@1; ALU_FUN=2;
//    one ALU_EN pulse; TX bytes 0xC8 then 0x00. CLK_GATE_EN is high only during FUN..ALU_WAIT.
//  Frame DD,00 with FIFO_FULL held high for 5 cycles in TX_LSB -> no TX_D_VLD while full; the two
//    bytes are emitted in order after release; no byte is lost or duplicated.
//  Bytes 0x55 in IDLE, then 0xAA during TX_MSB -> both ignored; no RF or ALU strobe.
//  RST low during OP_B of a CC frame -> all outputs 0 immediately; the next frame AA,01,FF
//    executes correctly.

Source files
------------

// File: rtl/sys_ctrl_alu_sequencer.sv
// Command-frame sequencer: UART RX bytes -> RF write/read and ALU ops,
// results streamed to the TX FIFO.
//
// Ports:
//   CLK, RST                  clock, async active-low reset
//   RX_P_DATA, RX_D_VLD       parsed RX byte and its strobe
//   ALU_OUT, ALU_OUT_VLD      registered ALU result and valid
//   RF_RD_DATA, RF_RD_DATA_VLD register-file read data and valid
//   FIFO_FULL                 TX FIFO full
//   ALU_EN, ALU_FUN           ALU enable pulse and held function code
//   CLK_GATE_EN               ALU clock-gate enable
//   RF_ADDR, RF_WR_EN,
//   RF_RD_EN, RF_WR_DATA      register-file access
//   TX_P_DATA, TX_D_VLD       TX FIFO write byte and strobe
module sys_ctrl_alu_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VLD,
  input  logic [DATA_WIDTH-1:0]   RF_RD_DATA,
  input  logic                    RF_RD_DATA_VLD,
  input  logic                    FIFO_FULL,
  output logic                    ALU_EN,
  output logic [FUN_WIDTH-1:0]    ALU_FUN,
  output logic                    CLK_GATE_EN,
  output logic [ADDR_WIDTH-1:0]   RF_ADDR,
  output logic                    RF_WR_EN,
  output logic                    RF_RD_EN,
  output logic [DATA_WIDTH-1:0]   RF_WR_DATA,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD
);

  localparam logic [DATA_WIDTH-1:0] CMD_WR  = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD  = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_FUN = DATA_WIDTH'(8'hDD);

  typedef enum logic [3:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    OP_A,
    OP_B,
    FUN,
    ALU_EXEC,
    ALU_WAIT,
    TX_LSB,
    TX_MSB,
    TX_RD
  } state_t;

  state_t state, state_nx;

  logic [ADDR_WIDTH-1:0]   addr_q, addr_nx;
  logic [2*DATA_WIDTH-1:0] res_q, res_nx;
  logic [DATA_WIDTH-1:0]   rd_q, rd_nx;
  logic [FUN_WIDTH-1:0]    fun_nx;
  logic [ADDR_WIDTH-1:0]   rf_addr_nx;
  logic [DATA_WIDTH-1:0]   wdat_nx;
  logic [DATA_WIDTH-1:0]   txd_nx;
  logic                    wr_nx;
  logic                    rd_en_nx;
  logic                    tx_nx;
  logic                    alu_en_nx;
  logic                    gate_nx;

  always_comb begin
    state_nx   = state;
    addr_nx    = addr_q;
    res_nx     = res_q;
    rd_nx      = rd_q;
    fun_nx     = ALU_FUN;
    rf_addr_nx = RF_ADDR;
    wdat_nx    = RF_WR_DATA;
    txd_nx     = TX_P_DATA;
    wr_nx      = 1'b0;
    rd_en_nx   = 1'b0;
    tx_nx      = 1'b0;
    unique case (state)
      IDLE: begin
        if (RX_D_VLD) begin
          unique case (1'b1)
            (RX_P_DATA == CMD_WR):  state_nx = WR_ADDR;
            (RX_P_DATA == CMD_RD):  state_nx = RD_ADDR;
            (RX_P_DATA == CMD_ALU): state_nx = OP_A;
            (RX_P_DATA == CMD_FUN): state_nx = FUN;
            default:                state_nx = IDLE;
          endcase
        end
      end
      WR_ADDR: begin
        if (RX_D_VLD) begin
          addr_nx  = RX_P_DATA[ADDR_WIDTH-1:0];
          state_nx = WR_DATA;
        end
      end
      WR_DATA: begin
        if (RX_D_VLD) begin
          wr_nx      = 1'b1;
          rf_addr_nx = addr_q;
          wdat_nx    = RX_P_DATA;
          state_nx   = IDLE;
        end
      end
      RD_ADDR: begin
        if (RX_D_VLD) begin
          rd_en_nx   = 1'b1;
          addr_nx    = RX_P_DATA[ADDR_WIDTH-1:0];
          rf_addr_nx = RX_P_DATA[ADDR_WIDTH-1:0];
          state_nx   = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (RF_RD_DATA_VLD) begin
          rd_nx    = RF_RD_DATA;
          state_nx = TX_RD;
        end
      end
      OP_A: begin
        if (RX_D_VLD) begin
          wr_nx      = 1'b1;
          rf_addr_nx = ADDR_WIDTH'(0);
          wdat_nx    = RX_P_DATA;
          state_nx   = OP_B;
        end
      end
      OP_B: begin
        if (RX_D_VLD) begin
          wr_nx      = 1'b1;
          rf_addr_nx = ADDR_WIDTH'(1);
          wdat_nx    = RX_P_DATA;
          state_nx   = FUN;
        end
      end
      FUN: begin
        if (RX_D_VLD) begin
          fun_nx   = RX_P_DATA[FUN_WIDTH-1:0];
          state_nx = ALU_EXEC;
        end
      end
      ALU_EXEC: state_nx = ALU_WAIT;
      ALU_WAIT: begin
        if (ALU_OUT_VLD) begin
          res_nx   = ALU_OUT;
          state_nx = TX_LSB;
        end
      end
      TX_LSB: begin
        if (!FIFO_FULL) begin
          tx_nx    = 1'b1;
          txd_nx   = res_q[DATA_WIDTH-1:0];
          state_nx = TX_MSB;
        end
      end
      TX_MSB: begin
        if (!FIFO_FULL) begin
          tx_nx    = 1'b1;
          txd_nx   = res_q[2*DATA_WIDTH-1:DATA_WIDTH];
          state_nx = IDLE;
        end
      end
      TX_RD: begin
        if (!FIFO_FULL) begin
          tx_nx    = 1'b1;
          txd_nx   = rd_q;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Enable and gate are registered from the next state so they are
  // high exactly while the FSM sits in the matching states.
  always_comb begin
    alu_en_nx = (state_nx == ALU_EXEC);
    gate_nx   = (state_nx == FUN) ||
                (state_nx == ALU_EXEC) ||
                (state_nx == ALU_WAIT);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      addr_q      <= '0;
      res_q       <= '0;
      rd_q        <= '0;
      ALU_EN      <= 1'b0;
      ALU_FUN     <= '0;
      CLK_GATE_EN <= 1'b0;
      RF_ADDR     <= '0;
      RF_WR_EN    <= 1'b0;
      RF_RD_EN    <= 1'b0;
      RF_WR_DATA  <= '0;
      TX_P_DATA   <= '0;
      TX_D_VLD    <= 1'b0;
    end else begin
      state       <= state_nx;
      addr_q      <= addr_nx;
      res_q       <= res_nx;
      rd_q        <= rd_nx;
      ALU_EN      <= alu_en_nx;
      ALU_FUN     <= fun_nx;
      CLK_GATE_EN <= gate_nx;
      RF_ADDR     <= rf_addr_nx;
      RF_WR_EN    <= wr_nx;
      RF_RD_EN    <= rd_en_nx;
      RF_WR_DATA  <= wdat_nx;
      TX_P_DATA   <= txd_nx;
      TX_D_VLD    <= tx_nx;
    end
  end

endmodule

// File: tb/tb_sys_ctrl_alu_sequencer.sv
// Randomized frame-level bench for sys_ctrl_alu_sequencer with RF/ALU
// responders and a frame-level expected-event model.
module tb_sys_ctrl_alu_sequencer;

  logic        CLK;
  logic        RST;
  logic [7:0]  RX_P_DATA;
  logic        RX_D_VLD;
  logic [15:0] ALU_OUT;
  logic        ALU_OUT_VLD;
  logic [7:0]  RF_RD_DATA;
  logic        RF_RD_DATA_VLD;
  logic        FIFO_FULL;
  logic        ALU_EN;
  logic [3:0]  ALU_FUN;
  logic        CLK_GATE_EN;
  logic [3:0]  RF_ADDR;
  logic        RF_WR_EN;
  logic        RF_RD_EN;
  logic [7:0]  RF_WR_DATA;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;

  sys_ctrl_alu_sequencer dut (
    .CLK(CLK), .RST(RST),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
    .RF_RD_DATA(RF_RD_DATA), .RF_RD_DATA_VLD(RF_RD_DATA_VLD),
    .FIFO_FULL(FIFO_FULL),
    .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .CLK_GATE_EN(CLK_GATE_EN),
    .RF_ADDR(RF_ADDR), .RF_WR_EN(RF_WR_EN), .RF_RD_EN(RF_RD_EN),
    .RF_WR_DATA(RF_WR_DATA),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  rmem [16];
  logic [7:0]  mem [16];
  logic [11:0] exp_wr[$], obs_wr[$];
  logic [3:0]  exp_rd[$], obs_rd[$];
  logic [3:0]  exp_alu[$], obs_alu[$];
  logic [7:0]  exp_tx[$], obs_tx[$];
  int p_wr = 0, p_rd = 0, p_alu = 0, p_tx = 0;
  logic full_force;
  logic rand_full;
  logic full_prev;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] alu_f(input logic [7:0] a,
                                        input logic [7:0] b,
                                        input logic [3:0] f);
    case (f[1:0])
      2'd0:    return {8'h00, a} + {8'h00, b};
      2'd1:    return {8'h00, a} - {8'h00, b};
      2'd2:    return {8'h00, a} * {8'h00, b};
      default: return {a, b};
    endcase
  endfunction

  // Register file and ALU behaving as the surrounding system would.
  always @(posedge CLK) begin
    ALU_OUT_VLD    <= 1'b0;
    RF_RD_DATA_VLD <= 1'b0;
    if (RF_WR_EN) rmem[RF_ADDR] <= RF_WR_DATA;
    if (RF_RD_EN) begin
      RF_RD_DATA     <= rmem[RF_ADDR];
      RF_RD_DATA_VLD <= 1'b1;
    end
    if (ALU_EN) begin
      ALU_OUT     <= alu_f(rmem[0], rmem[1], ALU_FUN);
      ALU_OUT_VLD <= 1'b1;
    end
  end

  task automatic full_drv();
    forever begin
      @(posedge CLK);
      #1;
      FIFO_FULL = rand_full ? ($urandom_range(0, 2) == 0) : full_force;
    end
  endtask

  task automatic monitor();
    int n;
    forever begin
      @(negedge CLK);
      if (RST) begin
        n = int'(RF_WR_EN) + int'(RF_RD_EN) + int'(ALU_EN) + int'(TX_D_VLD);
        if (n > 0) chk("strobe_excl", 32'(n), 32'd1);
        if (RF_WR_EN) obs_wr.push_back({RF_ADDR, RF_WR_DATA});
        if (RF_RD_EN) obs_rd.push_back(RF_ADDR);
        if (ALU_EN) begin
          obs_alu.push_back(ALU_FUN);
          chk("gate_at_en", 32'(CLK_GATE_EN), 32'd1);
        end
        if (ALU_OUT_VLD) chk("gate_at_vld", 32'(CLK_GATE_EN), 32'd1);
        if (TX_D_VLD) begin
          obs_tx.push_back(TX_P_DATA);
          chk("tx_when_full", 32'(full_prev), 32'd0);
          chk("gate_at_tx", 32'(CLK_GATE_EN), 32'd0);
        end
      end
      full_prev = FIFO_FULL;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(posedge CLK);
    @(posedge CLK);
    #1;
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    @(posedge CLK);
    #1;
    RX_D_VLD  = 1'b0;
  endtask

  function automatic int gap();
    return int'($urandom_range(0, 2));
  endfunction

  task automatic do_wr(input logic [7:0] a, input logic [7:0] d);
    send_byte(8'hAA, gap());
    send_byte(a, gap());
    send_byte(d, gap());
    exp_wr.push_back({a[3:0], d});
    mem[a[3:0]] = d;
  endtask

  task automatic do_rd(input logic [7:0] a);
    send_byte(8'hBB, gap());
    send_byte(a, gap());
    exp_rd.push_back(a[3:0]);
    exp_tx.push_back(mem[a[3:0]]);
  endtask

  task automatic do_alu(input bit ops, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] f);
    logic [15:0] r;
    if (ops) begin
      send_byte(8'hCC, gap());
      send_byte(a, gap());
      exp_wr.push_back({4'd0, a});
      mem[0] = a;
      send_byte(b, gap());
      exp_wr.push_back({4'd1, b});
      mem[1] = b;
    end else begin
      send_byte(8'hDD, gap());
    end
    send_byte(f, gap());
    exp_alu.push_back(f[3:0]);
    r = alu_f(mem[0], mem[1], f[3:0]);
    exp_tx.push_back(r[7:0]);
    exp_tx.push_back(r[15:8]);
  endtask

  task automatic settle();
    int t;
    t = 0;
    while ((obs_wr.size() < exp_wr.size() || obs_rd.size() < exp_rd.size() ||
            obs_alu.size() < exp_alu.size() || obs_tx.size() < exp_tx.size())
           && t < 400) begin
      @(posedge CLK);
      t++;
    end
    chk("settle_timeout", 32'(t < 400), 32'd1);
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    chk("gate_idle", 32'(CLK_GATE_EN), 32'd0);
    chk("n_wr", 32'(obs_wr.size()), 32'(exp_wr.size()));
    chk("n_rd", 32'(obs_rd.size()), 32'(exp_rd.size()));
    chk("n_alu", 32'(obs_alu.size()), 32'(exp_alu.size()));
    chk("n_tx", 32'(obs_tx.size()), 32'(exp_tx.size()));
    for (int i = p_wr; i < exp_wr.size() && i < obs_wr.size(); i++)
      chk("rf_wr", 32'(obs_wr[i]), 32'(exp_wr[i]));
    for (int i = p_rd; i < exp_rd.size() && i < obs_rd.size(); i++)
      chk("rf_rd", 32'(obs_rd[i]), 32'(exp_rd[i]));
    for (int i = p_alu; i < exp_alu.size() && i < obs_alu.size(); i++)
      chk("alu_fun", 32'(obs_alu[i]), 32'(exp_alu[i]));
    for (int i = p_tx; i < exp_tx.size() && i < obs_tx.size(); i++)
      chk("tx_byte", 32'(obs_tx[i]), 32'(exp_tx[i]));
    p_wr  = exp_wr.size();
    p_rd  = exp_rd.size();
    p_alu = exp_alu.size();
    p_tx  = exp_tx.size();
  endtask

  function automatic logic [31:0] outs();
    return 32'({ALU_EN, ALU_FUN, CLK_GATE_EN, RF_ADDR, RF_WR_EN,
                RF_RD_EN, RF_WR_DATA, TX_P_DATA, TX_D_VLD});
  endfunction

  initial begin
    int base;
    int kind;
    logic [7:0] j;
    RST        = 1'b0;
    RX_P_DATA  = 8'h00;
    RX_D_VLD   = 1'b0;
    FIFO_FULL  = 1'b0;
    full_force = 1'b0;
    rand_full  = 1'b0;
    full_prev  = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    fork
      full_drv();
      monitor();
    join_none
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_outs", outs(), 32'd0);
    @(negedge CLK);
    RST = 1'b1;

    for (int i = 0; i < 16; i++) begin
      do_wr(8'(i), 8'($urandom));
      settle();
    end

    do_wr(8'h05, 8'h3C);
    settle();
    do_rd(8'h05);
    settle();
    chk("spec_rd", 32'(obs_tx[obs_tx.size()-1]), 32'h3C);
    do_alu(1'b1, 8'h0A, 8'h14, 8'h02);
    settle();
    chk("spec_fun", 32'(ALU_FUN), 32'd2);
    chk("spec_lsb", 32'(obs_tx[obs_tx.size()-2]), 32'hC8);
    chk("spec_msb", 32'(obs_tx[obs_tx.size()-1]), 32'h00);

    full_force = 1'b1;
    base = obs_tx.size();
    do_alu(1'b0, 8'h00, 8'h00, 8'h00);
    repeat (9) @(posedge CLK);
    chk("full_hold", 32'(obs_tx.size()), 32'(base));
    full_force = 1'b0;
    settle();

    send_byte(8'h55, 0);
    full_force = 1'b1;
    base = obs_tx.size();
    do_alu(1'b0, 8'h00, 8'h00, 8'h01);
    repeat (6) @(posedge CLK);
    #2;
    full_force = 1'b0;
    @(posedge CLK);
    #2;
    full_force = 1'b1;
    repeat (2) @(posedge CLK);
    send_byte(8'hAA, 0);
    repeat (3) @(posedge CLK);
    chk("msb_hold", 32'(obs_tx.size()), 32'(base + 1));
    full_force = 1'b0;
    settle();

    send_byte(8'hCC, 1);
    send_byte(8'h77, 1);
    exp_wr.push_back({4'd0, 8'h77});
    mem[0] = 8'h77;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    #1;
    chk("mid_reset_outs", outs(), 32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    settle();
    do_wr(8'h01, 8'hFF);
    settle();

    rand_full = 1'b1;
    for (int n = 0; n < 60; n++) begin
      kind = int'($urandom_range(0, 4));
      case (kind)
        0: do_wr(8'($urandom), 8'($urandom));
        1: do_rd(8'($urandom));
        2: do_alu(1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
        3: do_alu(1'b0, 8'h00, 8'h00, 8'($urandom));
        default: begin
          j = 8'($urandom);
          while (j == 8'hAA || j == 8'hBB || j == 8'hCC || j == 8'hDD)
            j = 8'($urandom);
          send_byte(j, gap());
        end
      endcase
      if ((kind == 1 || kind == 2 || kind == 3) && $urandom_range(0, 1) == 1)
        send_byte(8'($urandom), 0);
      settle();
    end
    rand_full = 1'b0;
    repeat (2) @(posedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
